// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the execute-stage iterative multiply/divide unit.
//   - muldiv_op_e    : operation encodings carried on the unit's op input
//   - muldiv_state_e : sequencer states
//   - cnt_width()    : width of the step counter for a given operand width
//   - op_is_div(), op_is_signed() : decode helpers for the raw 2-bit op field
package alu_pkg;

  typedef enum logic [1:0] {
    OpMultu = 2'b00,
    OpMult  = 2'b01,
    OpDivu  = 2'b10,
    OpDiv   = 2'b11
  } muldiv_op_e;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRun   = 2'b01,
    StFixup = 2'b10
  } muldiv_state_e;

  // The counter is loaded with the full step count, so it must hold WIDTH itself.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == OpDivu) || (op == OpDiv);
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OpMult) || (op == OpDiv);
  endfunction

endpackage

// File: rtl/muldiv_abs.sv
// muldiv_abs: combinational two's-complement conditional negate.
// Used both to take the magnitude of a signed operand (i_neg = sign bit) and to
// restore the sign of a result after the unsigned magnitude datapath.
//   i_value [WIDTH-1:0] : value to condition
//   i_neg               : 1 = output the two's-complement negation, 0 = pass through
//   o_value [WIDTH-1:0] : conditioned value (modulo 2^WIDTH)
module muldiv_abs #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_value,
  input  logic             i_neg,
  output logic [WIDTH-1:0] o_value
);

  always_comb begin
    o_value = i_neg ? (~i_value + WIDTH'(1)) : i_value;
  end

endmodule

// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative MULTU/MULT/DIVU/DIV unit with architectural hi/lo registers.
// One radix-2 step per cycle over unsigned magnitudes, followed by a sign-fixup cycle.
// Configuration macro: ALU_MULDIV_EARLY_OUT_EN (multiplies stop once the remaining
// multiplier magnitude is zero; division timing is unaffected).
//   i_clk          : clock, all state on the rising edge
//   i_reset        : synchronous active-high reset, aborts any operation in flight
//   i_start        : request, sampled only in idle
//   i_op [1:0]     : 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   i_input_a      : multiplicand / dividend
//   i_input_b      : multiplier / divisor
//   o_hi           : product upper half / remainder
//   o_lo           : product lower half / quotient
//   o_busy         : operation in progress (RUN or FIXUP)
//   o_done         : one-cycle completion pulse, coincident with new hi/lo
//   o_div_zero     : last completed operation was a division by zero
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_input_a,
  input  logic [WIDTH-1:0] i_input_b,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_div_zero
);

  localparam int unsigned CntW = cnt_width(WIDTH);

`ifdef ALU_MULDIV_EARLY_OUT_EN
  localparam bit EarlyOut = 1'b1;
`else
  localparam bit EarlyOut = 1'b0;
`endif

  // Sequencer and datapath state.
  muldiv_state_e      r_state;
  logic               r_is_div;
  logic               r_neg_res;   // operand signs differ: negate product / quotient
  logic               r_neg_rem;   // dividend negative: negate remainder
  logic               r_dz;        // operation in flight is a division by zero
  logic [CntW-1:0]    r_cnt;
  // Multiply: running product. Divide: {partial remainder, dividend/quotient}.
  // Divide by zero: the final {hi, lo} pattern, passed straight through FIXUP.
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;     // multiplicand magnitude, shifted left each step
  logic [WIDTH-1:0]   r_opb;       // multiplier (shifted right each step) or divisor

  // Architectural outputs.
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_busy;
  logic               r_done;
  logic               r_div_zero;

  // Operand conditioning.
  logic               w_is_div;
  logic               w_is_signed;
  logic               w_neg_a;
  logic               w_neg_b;
  logic               w_b_zero;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;

  always_comb begin
    w_is_div    = op_is_div(i_op);
    w_is_signed = op_is_signed(i_op);
    w_neg_a     = w_is_signed & i_input_a[WIDTH-1];
    w_neg_b     = w_is_signed & i_input_b[WIDTH-1];
    w_b_zero    = (i_input_b == '0);
  end

  muldiv_abs #(
    .WIDTH (WIDTH)
  ) u_abs_a (
    .i_value (i_input_a),
    .i_neg   (w_neg_a),
    .o_value (w_mag_a)
  );

  muldiv_abs #(
    .WIDTH (WIDTH)
  ) u_abs_b (
    .i_value (i_input_b),
    .i_neg   (w_neg_b),
    .o_value (w_mag_b)
  );

  // Shift-add multiply step.
  logic [2*WIDTH-1:0] w_mul_acc;
  logic [WIDTH-1:0]   w_mul_opb;

  always_comb begin
    w_mul_acc = r_opb[0] ? (r_acc + r_mcand) : r_acc;
    w_mul_opb = r_opb >> 1;
  end

  // Restoring divide step: shift the next dividend bit into the remainder, then
  // try to subtract. The borrow out of the (WIDTH+1)-bit subtract decides the bit.
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH:0]     w_rem_sub;
  logic [2*WIDTH-1:0] w_div_acc;

  always_comb begin
    w_rem_sh  = r_acc[2*WIDTH-1:WIDTH-1];
    w_rem_sub = w_rem_sh - {1'b0, r_opb};
    if (!w_rem_sub[WIDTH]) begin
      w_div_acc = {w_rem_sub[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
    end else begin
      w_div_acc = {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
    end
  end

  // RUN ends after the last counted step, or earlier for a multiply whose
  // remaining multiplier has run out of set bits.
  logic w_run_last;

  always_comb begin
    w_run_last = (r_cnt == CntW'(1)) || (EarlyOut && !r_is_div && (w_mul_opb == '0));
  end

  // Sign correction applied in FIXUP.
  logic [2*WIDTH-1:0] w_fix_prod;
  logic [WIDTH-1:0]   w_fix_quo;
  logic [WIDTH-1:0]   w_fix_rem;

  muldiv_abs #(
    .WIDTH (2 * WIDTH)
  ) u_fix_prod (
    .i_value (r_acc),
    .i_neg   (r_neg_res),
    .o_value (w_fix_prod)
  );

  muldiv_abs #(
    .WIDTH (WIDTH)
  ) u_fix_quo (
    .i_value (r_acc[WIDTH-1:0]),
    .i_neg   (r_neg_res),
    .o_value (w_fix_quo)
  );

  muldiv_abs #(
    .WIDTH (WIDTH)
  ) u_fix_rem (
    .i_value (r_acc[2*WIDTH-1:WIDTH]),
    .i_neg   (r_neg_rem),
    .o_value (w_fix_rem)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= StIdle;
      r_is_div   <= 1'b0;
      r_neg_res  <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_dz       <= 1'b0;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_mcand    <= '0;
      r_opb      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_is_div  <= w_is_div;
            r_neg_res <= w_neg_a ^ w_neg_b;
            r_neg_rem <= w_neg_a;
            r_dz      <= w_is_div & w_b_zero;
            r_cnt     <= CntW'(WIDTH);
            r_mcand   <= {{WIDTH{1'b0}}, w_mag_a};
            r_opb     <= w_mag_b;
            r_busy    <= 1'b1;
            if (w_is_div && w_b_zero) begin
              r_acc   <= {i_input_a, {WIDTH{1'b1}}};
              r_state <= StFixup;
            end else if (w_is_div) begin
              r_acc   <= {{WIDTH{1'b0}}, w_mag_a};
              r_state <= StRun;
            end else begin
              r_acc   <= '0;
              // A zero multiplier has nothing to accumulate when stopping early.
              r_state <= (EarlyOut && (w_mag_b == '0)) ? StFixup : StRun;
            end
          end
        end
        StRun: begin
          if (r_is_div) begin
            r_acc <= w_div_acc;
          end else begin
            r_acc   <= w_mul_acc;
            r_mcand <= r_mcand << 1;
            r_opb   <= w_mul_opb;
          end
          r_cnt <= r_cnt - CntW'(1);
          if (w_run_last) begin
            r_state <= StFixup;
          end
        end
        StFixup: begin
          if (r_dz) begin
            r_hi <= r_acc[2*WIDTH-1:WIDTH];
            r_lo <= r_acc[WIDTH-1:0];
          end else if (r_is_div) begin
            r_hi <= w_fix_rem;
            r_lo <= w_fix_quo;
          end else begin
            r_hi <= w_fix_prod[2*WIDTH-1:WIDTH];
            r_lo <= w_fix_prod[WIDTH-1:0];
          end
          r_div_zero <= r_dz;
          r_done     <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= StIdle;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  always_comb begin
    o_hi       = r_hi;
    o_lo       = r_lo;
    o_busy     = r_busy;
    o_done     = r_done;
    o_div_zero = r_div_zero;
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: scoreboard bench for alu_muldiv (WIDTH = 32).
// Expected results are queued when an operation is issued and compared when done pulses.
module tb_alu_muldiv;

  localparam int unsigned W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1:0]    op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;
  logic          busy;
  logic          done;
  logic          dz;

  always #5 clk = ~clk;

  alu_muldiv #(
    .WIDTH (W)
  ) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_start    (start),
    .i_op       (op),
    .i_input_a  (a),
    .i_input_b  (b),
    .o_hi       (hi),
    .o_lo       (lo),
    .o_busy     (busy),
    .o_done     (done),
    .o_div_zero (dz)
  );

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           lat;
    int           t0;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Completion latency in cycles counted from the cycle start is sampled.
  function automatic int exp_lat(input logic [1:0] o, input logic [W-1:0] bb);
`ifdef ALU_MULDIV_EARLY_OUT_EN
    logic [W-1:0] m;
    int k;
`endif
    if (o[1] && bb == 0) return 2;
`ifdef ALU_MULDIV_EARLY_OUT_EN
    if (!o[1]) begin
      m = (o[0] && bb[W-1]) ? (~bb + 32'd1) : bb;
      k = 0;
      for (int i = 0; i < int'(W); i++) if (m[i]) k = i + 1;
      return k + 2;
    end
`endif
    return int'(W) + 2;
  endfunction

  // Reference model built on native 64-bit / signed arithmetic.
  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb);
    exp_t e;
    logic [63:0] p;
    logic signed [63:0] sa;
    logic signed [63:0] sbv;
    logic signed [31:0] qa;
    logic signed [31:0] qb;
    e.dz  = 1'b0;
    e.lat = exp_lat(o, bb);
    e.t0  = 0;
    e.hi  = '0;
    e.lo  = '0;
    case (o)
      2'b00: begin
        p = {32'd0, aa} * {32'd0, bb};
        e.hi = p[63:32];
        e.lo = p[31:0];
      end
      2'b01: begin
        sa  = {{32{aa[31]}}, aa};
        sbv = {{32{bb[31]}}, bb};
        p   = sa * sbv;
        e.hi = p[63:32];
        e.lo = p[31:0];
      end
      default: begin
        if (bb == 0) begin
          e.hi = aa;
          e.lo = '1;
          e.dz = 1'b1;
        end else if (!o[0]) begin
          e.lo = aa / bb;
          e.hi = aa % bb;
        end else if (aa == 32'h8000_0000 && bb == 32'hffff_ffff) begin
          e.lo = 32'h8000_0000;
          e.hi = '0;
        end else begin
          qa = aa;
          qb = bb;
          e.lo = qa / qb;
          e.hi = qa % qb;
        end
      end
    endcase
    return e;
  endfunction

  // Completion monitor: pops the oldest expectation on each done pulse.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 64'(done), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("hi", 64'(hi), 64'(mon_e.hi));
        check("lo", 64'(lo), 64'(mon_e.lo));
        check("div_zero", 64'(dz), 64'(mon_e.dz));
        check("latency", 64'(cyc - mon_e.t0), 64'(mon_e.lat));
      end
    end
  end

  // Issues one operation and returns in its done cycle so the next call issues
  // back-to-back. glitch > 0 pulses start (with a different A) in that busy cycle.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                        input logic [W-1:0] eh, input logic [W-1:0] el, input logic edz,
                        input int glitch);
    exp_t e;
    int   n;
    int   busy_n;
    e.hi  = eh;
    e.lo  = el;
    e.dz  = edz;
    e.lat = exp_lat(o, bb);
    e.t0  = cyc;
    sb.push_back(e);
    op    = o;
    a     = aa;
    b     = bb;
    start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    n      = 1;
    busy_n = 0;
    while (!done && n < 200) begin
      if (busy) busy_n++;
      if (n == glitch) begin
        start = 1'b1;
        a     = ~aa;
      end else if (n == glitch + 1) begin
        start = 1'b0;
        a     = aa;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    a     = aa;
    if (!done) begin
      check("done_seen", 64'(done), 64'd1);
      sb.delete();
    end else begin
      check("busy_cycles", 64'(busy_n), 64'(e.lat - 1));
      check("busy_in_done", 64'(busy), 64'd0);
    end
  endtask

  initial begin
    exp_t e;
    logic [1:0]   ro;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int           done_n;

    rst   = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dz", 64'(dz), 64'd0);

    // Directed vectors.
    run_op(2'b00, 32'hffff_ffff, 32'hffff_ffff, 32'hffff_fffe, 32'h0000_0001, 1'b0, 0);
    run_op(2'b01, 32'hffff_fffd, 32'd5, 32'hffff_ffff, 32'hffff_fff1, 1'b0, 0);
    run_op(2'b00, 32'd7, 32'd3, 32'd0, 32'd21, 1'b0, 0);
    run_op(2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 0);
    run_op(2'b11, 32'hffff_fff9, 32'd2, 32'hffff_ffff, 32'hffff_fffd, 1'b0, 0);
    run_op(2'b11, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hffff_ffff, 1'b1, 0);
    run_op(2'b11, 32'h8000_0000, 32'hffff_ffff, 32'd0, 32'h8000_0000, 1'b0, 0);
    // Start pulsed while busy must be ignored.
    run_op(2'b00, 32'h0000_1234, 32'h0000_5678, 32'd0, 32'h0626_0060, 1'b0, 10);
    run_op(2'b01, 32'd0, 32'hffff_ffff, 32'd0, 32'd0, 1'b0, 0);

    // Random operations, issued back-to-back.
    for (int i = 0; i < 20; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = '0;
        1:       rb = 32'($urandom_range(0, 15));
        2:       rb = ~32'($urandom_range(0, 15));
        default: rb = $urandom;
      endcase
      e = model(ro, ra, rb);
      run_op(ro, ra, rb, e.hi, e.lo, e.dz, 0);
    end

    // Reset in cycle 15 of a divide aborts it without a done pulse.
    op    = 2'b10;
    a     = 32'd1000;
    b     = 32'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_hi", 64'(hi), 64'd0);
    check("abort_lo", 64'(lo), 64'd0);
    check("abort_dz", 64'(dz), 64'd0);
    done_n = 0;
    repeat (40) begin
      if (done) done_n++;
      @(negedge clk);
    end
    check("abort_no_done", 64'(done_n), 64'd0);

    // Unit remains usable after the abort.
    run_op(2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 0);
    repeat (3) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_muldiv.md
# alu_muldiv

Iterative multiply/divide unit with a parametrised width, placed beside the combinational `alu` in the execute stage. It implements the MIPS `mult`, `multu`, `div` and `divu` operations over several cycles using a start/done handshake. Results go into architectural `hi` and `lo` registers, which `mfhi`/`mflo` read directly. The core stalls while `busy` is high.

## Interface
- `WIDTH`, 32: operand width and width of each of `hi`/`lo`.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: request; sampled only when not busy.
- `op`  in  2: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- `inputA`  in  WIDTH: multiplicand / dividend.
- `inputB`  in  WIDTH: multiplier / divisor.
- `hi`  out  WIDTH: product upper half / remainder.
- `lo`  out  WIDTH: product lower half / quotient.
- `busy`  out  1: operation in progress.
- `done`  out  1: one-cycle completion pulse.
- `divZero`  out  1: last completed op was a division with `inputB`=0.

## Operation
- States: IDLE, RUN, FIXUP.
- **Reset:**
  - State goes to IDLE.
  - `hi`, `lo` = 0; `busy`, `done`, `divZero` = 0.
  - Reset during RUN/FIXUP aborts the operation; no `done` is produced.
- **IDLE:**
  - On `start`=1, latch `op`, `inputA`, `inputB`.
  - For signed ops, latch magnitudes plus result-sign flags.
  - Go to RUN. A division by zero goes directly to FIXUP.
- **RUN:** one radix-2 step per cycle, WIDTH cycles, with a step counter.
  - Multiply: shift-add, 2·WIDTH-bit accumulator.
  - Divide: restoring, unsigned magnitudes.
- **FIXUP:**
  - Apply sign correction: product negated if the operand signs differ; quotient negated if the signs differ; remainder takes the dividend's sign.
  - Write `hi`/`lo`/`divZero` and go to IDLE.
- **Divide by zero:** `hi` = `inputA`, `lo` = all ones, `divZero` = 1.
- **Signed overflow** (most-negative ÷ −1): `lo` = most-negative, `hi` = 0. This is the natural result of the magnitude path.
- All arithmetic is modulo 2^WIDTH per half. Unsigned ops ignore sign bits.
- `hi`/`lo`/`divZero` hold their values until the next completion. They are not cleared by `start`.
- `start` while busy is ignored (no queueing). The core must not change operands or assert `start` then.

## Timing
- Cycle 0 is the cycle in which `start` is sampled high in IDLE.
- Normal path:
  - RUN occupies cycles 1..WIDTH.
  - FIXUP occupies cycle WIDTH+1.
  - `done`=1 and new `hi`/`lo` are visible in cycle WIDTH+2 (34 for WIDTH=32).
- Divide by zero: FIXUP in cycle 1; `done` in cycle 2.
- `busy` = 1 exactly while the state is RUN or FIXUP; it is 0 in cycle 0 and in the `done` cycle.
- `done` is registered. During the `done` cycle the state is IDLE, so a new `start` in that cycle is accepted (back-to-back issue).
- Outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- Macro: `ALU_MULDIV_EARLY_OUT_EN`.
- **Defined:**
  - Multiply ops leave RUN as soon as the remaining multiplier magnitude is zero.
  - RUN length = bit length k of |B|; RUN is skipped if |B| = 0.
  - `done` arrives in cycle k+2.
  - Division timing is unchanged.
- **Undefined:** every non-div-by-zero op has the fixed latency WIDTH+2.

## Structure
- Package `alu_pkg` holds:
  - op encodings (MULTU/MULT/DIVU/DIV);
  - state enum (IDLE/RUN/FIXUP);
  - the step-counter width function clog2(WIDTH+1).
- Sub-module `muldiv_abs` (combinational, parametrised WIDTH): two's-complement magnitude and conditional negate. It is instantiated for operand conditioning and for the FIXUP sign correction.
- Datapath and FSM live in `alu_muldiv`.

## Test plan
- MULTU 0xffffffff × 0xffffffff → `hi`=0xfffffffe, `lo`=0x00000001; `done` in cycle 34; `busy` high in cycles 1–33.
- MULT 0xfffffffd (−3) × 5 → `hi`=0xffffffff, `lo`=0xfffffff1. With `ALU_MULDIV_EARLY_OUT_EN`: MULTU 7×3 → `lo`=21, `done` in cycle 4.
- DIVU 100 ÷ 7 → `lo`=14, `hi`=2. DIV 0xfffffff9 (−7) ÷ 2 → `lo`=0xfffffffd, `hi`=0xffffffff.
- DIV 0x12345678 ÷ 0 → `hi`=0x12345678, `lo`=0xffffffff, `divZero`=1, `done` in cycle 2. The next valid DIV clears `divZero`.
- DIV 0x80000000 ÷ 0xffffffff → `lo`=0x80000000, `hi`=0, `divZero`=0.
- Handshake and reset:
  - `start` pulsed at cycle 10 of a busy op: ignored, results from the first op only.
  - New `start` in the `done` cycle: accepted.
  - `reset` in cycle 15: next cycle `busy`=0, `hi`=`lo`=0, no `done` pulse.
